r2b_tile_assembler: RTL and testbench

R2B_TILE_ASSEMBLER -- requirements
Module: r2b_tile_assembler

---
 rtl/r2b_tile_assembler.sv | 83 ++++++++
 tb/tb_r2b_tile_assembler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/r2b_tile_assembler.sv
// r2b_tile_assembler: collects ROWS softmax row tiles, then emits them as BLOCK_SIZE x BLOCK_SIZE blocks
// Ports: clk, rst_n (sync, active-low); in_valid/in_row_idx/in_data row tile input, in_ready high while filling;
// out_valid/out_ready/out_data block handshake, block-row-major order; slice_last pulses after the final block;
// err_overflow sticky drop flag, present only when R2B_OVERFLOW_CHK_EN is defined (otherwise tied 0).
module r2b_tile_assembler #(
    parameter int WIDTH      = 16,
    parameter int ROWS       = 4,
    parameter int TILE_COLS  = 8,
    parameter int BLOCK_SIZE = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic [$clog2(ROWS):0]                  in_row_idx,
    input  logic [WIDTH*TILE_COLS-1:0]             in_data,
    output logic                                   in_ready,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] out_data,
    output logic                                   slice_last,
    output logic                                   err_overflow
);
    localparam int AW  = $clog2(ROWS);
    localparam int NBR = ROWS / BLOCK_SIZE;
    localparam int NBC = TILE_COLS / BLOCK_SIZE;
    localparam int BRW = NBR > 1 ? $clog2(NBR) : 1;
    localparam int BCW = NBC > 1 ? $clog2(NBC) : 1;
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state, state_nxt;
    logic [WIDTH*TILE_COLS-1:0] row_mem [ROWS];
    logic [ROWS-1:0] present, wr_mask;
    logic [BRW-1:0] br;
    logic [BCW-1:0] bc;
    logic wr_en, xfer, bc_max, last_blk;
    assign wr_en    = (state == FILL) && in_valid && (in_row_idx < (AW+1)'(ROWS));
    assign wr_mask  = wr_en ? ROWS'(1) << in_row_idx[AW-1:0] : '0;
    assign bc_max   = bc == BCW'(NBC - 1);
    assign last_blk = bc_max && (br == BRW'(NBR - 1));
    assign xfer     = out_valid && out_ready;
    always_ff @(posedge clk)
        state <= !rst_n ? FILL : state_nxt;
    // Completion looks at the bitmap including this cycle's write so DRAIN starts one cycle after the last row.
    always_comb
        state_nxt = (state == FILL) ? ((&(present | wr_mask)) ? DRAIN : FILL)
                                    : ((xfer && last_blk) ? FILL : DRAIN);
    always_comb begin
        in_ready  = state == FILL;
        out_valid = state == DRAIN;
    end
    always_ff @(posedge clk)
        if (wr_en) row_mem[in_row_idx[AW-1:0]] <= in_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            present    <= '0;
            br         <= '0;
            bc         <= '0;
            slice_last <= 1'b0;
        end else begin
            slice_last <= xfer && last_blk;
            present    <= (xfer && last_blk) ? '0 : present | wr_mask;
            if (xfer) begin
                bc <= bc_max ? '0 : bc + 1'b1;
                if (bc_max) br <= (br == BRW'(NBR - 1)) ? '0 : br + 1'b1;
            end
        end
    end
    for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_r
        for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_c
            assign out_data[(r*BLOCK_SIZE+c)*WIDTH +: WIDTH] =
                row_mem[AW'(int'(br)*BLOCK_SIZE + r)][(int'(bc)*BLOCK_SIZE + c)*WIDTH +: WIDTH];
        end
    end
`ifdef R2B_OVERFLOW_CHK_EN
    logic err_q;
    // Any in_valid that does not write (DRAIN or out-of-range row) is a dropped tile.
    always_ff @(posedge clk)
        if (!rst_n) err_q <= 1'b0;
        else if (in_valid && !wr_en) err_q <= 1'b1;
    assign err_overflow = err_q;
`else
    assign err_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_r2b_tile_assembler.sv
// tb_r2b_tile_assembler: directed bench with a slice-level reference model for r2b_tile_assembler
module tb_r2b_tile_assembler;
    localparam int W  = 16;
    localparam int R  = 4;
    localparam int TC = 8;
    localparam int BS = 2;
    localparam int NB = (R/BS) * (TC/BS);
    localparam int BW = W*BS*BS;
`ifdef R2B_OVERFLOW_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0] in_row_idx = '0;
    logic [W*TC-1:0] in_data = '0;
    logic in_ready, out_valid, slice_last, err_overflow;
    logic [BW-1:0] out_data;
    always #5 clk = ~clk;
    r2b_tile_assembler #(.WIDTH(W), .ROWS(R), .TILE_COLS(TC), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_row_idx(in_row_idx),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .slice_last(slice_last), .err_overflow(err_overflow)
    );
    int n_tests = 0, n_fail = 0, n_sl = 0;
    bit chk_on = 1'b0;
    logic [BW-1:0] cap[$], ref_q[$];
    task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Reference model: a slice is a set of rows; once all are present the slice is a list of NB blocks.
    bit m_drain = 1'b0, m_sl = 1'b0, m_err = 1'b0;
    bit [R-1:0] m_present = '0;
    int m_blk = 0;
    logic [W-1:0] mb [R][TC];
    always @(posedge clk) begin
        if (!rst_n) begin
            m_drain = 0; m_present = '0; m_blk = 0; m_sl = 0; m_err = 0;
        end else begin
            m_sl = 0;
            if (m_drain) begin
                if (in_valid) m_err = m_err | ERR_EN;
                if (out_ready) begin
                    m_blk++;
                    if (m_blk == NB) begin
                        m_drain = 0; m_present = '0; m_blk = 0; m_sl = 1;
                    end
                end
            end else if (in_valid) begin
                if (in_row_idx < R) begin
                    for (int c = 0; c < TC; c++) mb[in_row_idx[1:0]][c] = in_data[c*W +: W];
                    m_present[in_row_idx[1:0]] = 1'b1;
                    if (&m_present) m_drain = 1;
                end else m_err = m_err | ERR_EN;
            end
        end
    end
    function automatic logic [BW-1:0] exp_blk(int k);
        logic [BW-1:0] v;
        int brow = k / (TC/BS), bcol = k % (TC/BS);
        for (int r = 0; r < BS; r++)
            for (int c = 0; c < BS; c++)
                v[(r*BS+c)*W +: W] = mb[brow*BS+r][bcol*BS+c];
        return v;
    endfunction
    always @(negedge clk) begin
        if (chk_on) begin
            check("in_ready", in_ready, !m_drain);
            check("out_valid", out_valid, m_drain);
            check("slice_last", slice_last, m_sl);
            check("err_overflow", err_overflow, m_err);
            if (m_drain) check("out_data", out_data, exp_blk(m_blk));
        end
        if (out_valid && out_ready) cap.push_back(out_data);
        if (slice_last) n_sl++;
    end
    function automatic logic [W*TC-1:0] mk_row(int row);
        logic [W*TC-1:0] v;
        for (int c = 0; c < TC; c++) v[c*W +: W] = W'(row*16 + c);
        return v;
    endfunction
    function automatic logic [BW-1:0] pack4(logic [W-1:0] e00, logic [W-1:0] e01, logic [W-1:0] e10, logic [W-1:0] e11);
        return {e11, e10, e01, e00};
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic put_row(int idx, logic [W*TC-1:0] d);
        in_valid = 1'b1;
        in_row_idx = idx[2:0];
        in_data = d;
        cyc();
        in_valid = 1'b0;
    endtask
    task automatic put_all();
        for (int i = 0; i < R; i++) put_row(i, mk_row(i));
    endtask
    task automatic wait_blocks(int n);
        for (int i = 0; i < 200 && cap.size() < n; i++) cyc();
        check("blocks_seen", cap.size(), n);
    endtask
    task automatic end_slice(string nm);
        wait_blocks(NB);
        cyc();
        cyc();
        check({nm, "_slice_last_count"}, n_sl, 1);
        for (int i = 0; i < NB; i++) check({nm, "_block"}, cap[i], ref_q[i]);
        cap.delete();
        n_sl = 0;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
    initial begin
        in_valid = 1'b1;
        in_row_idx = 3'd0;
        in_data = '1;
        cyc();
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_slice_last", slice_last, 0);
        check("rst_err", err_overflow, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) put_row(i, mk_row(i));
        @(negedge clk);
        check("basic_before_last_row", out_valid, 0);
        put_row(3, mk_row(3));
        @(negedge clk);
        check("basic_latency", out_valid, 1);
        wait_blocks(NB);
        cyc();
        cyc();
        check("basic_slice_last_count", n_sl, 1);
        check("basic_block0", cap[0], pack4(0, 1, 16, 17));
        check("basic_block7", cap[7], pack4(38, 39, 54, 55));
        ref_q = cap;
        cap.delete();
        n_sl = 0;
        put_row(2, mk_row(2));
        put_row(0, mk_row(0));
        put_row(3, mk_row(3));
        @(negedge clk);
        check("ooo_not_done", out_valid, 0);
        put_row(1, mk_row(1));
        @(negedge clk);
        check("ooo_done", out_valid, 1);
        end_slice("ooo");
        out_ready = 1'b0;
        put_all();
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_block3", out_data, pack4(6, 7, 22, 23));
            cyc();
        end
        put_row(0, '1);
        @(negedge clk);
        check("drain_drop_err", err_overflow, ERR_EN);
        check("drain_drop_data", out_data, pack4(6, 7, 22, 23));
        out_ready = 1'b1;
        end_slice("stall");
        put_row(0, mk_row(0));
        put_row(1, mk_row(1));
        put_row(2, mk_row(2));
        put_row(1, {TC{16'hAAAA}});
        put_row(4, '1);
        @(negedge clk);
        check("rewrite_no_early", out_valid, 0);
        put_row(3, mk_row(3));
        wait_blocks(NB);
        check("rewrite_block0", cap[0], pack4(0, 1, 16'hAAAA, 16'hAAAA));
        check("rewrite_block3", cap[3], pack4(6, 7, 16'hAAAA, 16'hAAAA));
        check("rewrite_block7", cap[7], ref_q[7]);
        cyc();
        cyc();
        cap.delete();
        n_sl = 0;
        put_all();
        for (int i = 0; i < NB - 1; i++) cyc();
        put_row(0, '1);
        @(negedge clk);
        check("final_xfer_in_ready", in_ready, 1);
        for (int i = 1; i < R; i++) put_row(i, mk_row(i));
        @(negedge clk);
        check("final_xfer_dropped", out_valid, 0);
        put_row(0, mk_row(0));
        wait_blocks(2*NB);
        cyc();
        cyc();
        check("final_xfer_slices", n_sl, 2);
        for (int i = 0; i < NB; i++) check("final_xfer_block", cap[NB+i], ref_q[i]);
        cap.delete();
        n_sl = 0;
        put_all();
        wait_blocks(5);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err", err_overflow, 0);
        cap.delete();
        n_sl = 0;
        put_all();
        end_slice("midrst");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
